// File: rtl/mult_share_arbiter_if.sv
// Bundle between the multiplier-sharing arbiter, its requesters, the shared multiplier and the response consumer.
// Latency: none; this file only groups the signals.
// Backpressure: valid/ready on both the request side and the response side.
interface mult_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int PW   = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [DW-1:0]      mult_a;
  logic [DW-1:0]      mult_b;
  logic [PW-1:0]      mult_out;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [PW-1:0]      rsp_data;
  logic               busy;

  // Requester/multiplier/consumer side of the bundle.
  modport master (
    output req_valid, req_a, req_b, mult_out, rsp_ready,
    input  req_ready, mult_a, mult_b, rsp_valid, rsp_id, rsp_data, busy
  );

  // Arbiter side of the bundle.
  modport slave (
    input  req_valid, req_a, req_b, mult_out, rsp_ready,
    output req_ready, mult_a, mult_b, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational multiplier among NREQ requesters.
// Latency: accept edge T, product captured at edge T+1, rsp_valid high from then until the response handshake.
// Backpressure: one transaction in flight; req_ready stays low outside IDLE, and RESP holds until rsp_ready.
module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int PW   = 8
) (
  input logic               clk,
  input logic               rst,
  mult_share_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = IDW + 1;  // one extra bit so ptr+offset can exceed NREQ before wrapping

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [DW-1:0]   op_a_q;
  logic [DW-1:0]   op_b_q;
  logic [PW-1:0]   rsp_data_q;
  logic [IDW-1:0]  rsp_id_q;
  logic            rsp_valid_q;
  logic            busy_q;

  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  logic [CW-1:0]   cand;
  logic [DW-1:0]   sel_a_d;
  logic [DW-1:0]   sel_b_d;
  logic [NREQ-1:0] req_ready_d;

  // Pick the first valid requester after the pointer, wrapping modulo NREQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!gnt_vld && bus.req_valid[cand[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  // Steer the winner's operands toward the operand registers.
  always_comb begin
    sel_a_d = '0;
    sel_b_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a_d = bus.req_a[i*DW +: DW];
        sel_b_d = bus.req_b[i*DW +: DW];
      end
    end
  end

  // One-hot accept on the winner, only while idle and out of reset.
  always_comb begin
    req_ready_d = '0;
    if (!rst && (state_q == IDLE) && gnt_vld) req_ready_d[gnt_idx] = 1'b1;
  end

  // Sequencer: latch operands, give the multiplier a settle cycle, then hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDW'(NREQ - 1);
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            op_a_q   <= sel_a_d;
            op_b_q   <= sel_b_d;
            rsp_id_q <= gnt_idx;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          rsp_data_q  <= bus.mult_out;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          // The pointer moves only on a completed response, which is what makes rotation fair.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rr_ptr_q    <= rsp_id_q;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_d;
  assign bus.mult_a    = op_a_q;
  assign bus.mult_b    = op_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with an 8-bit truncating multiplier model on the mult ports.
// Latency: expected responses are queued when stimulus is driven and popped when the DUT responds.
// Backpressure: exercises rsp_ready stalls, retraction and reset in the middle of a transaction.
module tb_mult_share_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int PW   = 8;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mult_share_arbiter_if #(.NREQ(NREQ), .DW(DW), .PW(PW)) bus ();

  mult_share_arbiter #(.NREQ(NREQ), .DW(DW), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External shared multiplier: full product, truncated to PW bits.
  logic [2*DW-1:0] full_prod;
  assign full_prod    = {{DW{1'b0}}, bus.mult_a} * {{DW{1'b0}}, bus.mult_b};
  assign bus.mult_out = full_prod[PW-1:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[id*DW +: DW] = a;
    bus.req_b[id*DW +: DW] = b;
  endtask

  task automatic expect_rsp(input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  // Wait for a response, compare it against the scoreboard head, then complete the handshake.
  task automatic wait_rsp(input int budget);
    exp_t e;
    int   n = 0;
    while (!bus.rsp_valid && n < budget) begin
      step();
      n++;
    end
    check("rsp_timeout", bus.rsp_valid, 1);
    check("sb_nonempty", sb.size() != 0, 1);
    if (bus.rsp_valid && sb.size() != 0) begin
      e = sb.pop_front();
      check("rsp_id", bus.rsp_id, e.id);
      check("rsp_data", bus.rsp_data, e.data);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("ready_in_rsp_hs", bus.req_ready, 0);
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_txn(input int id, input logic [7:0] a, input logic [7:0] b, input logic [7:0] p);
    set_op(id, a, b);
    bus.req_valid = 4'b0001 << id;
    expect_rsp(id[1:0], p);
    #1;
    check("txn_ready", bus.req_ready, 4'b0001 << id);
    step();
    bus.req_valid = '0;
    wait_rsp(6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   gnt_exp[6];
    int   acc;
    int   rsp;
    int   last_acc;
    int   cyc;
    int   g;
    exp_t e;

    // Reset state, with a request already pending that must not be accepted.
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = 4'b0001;
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_mult_a", bus.mult_a, 0);
    check("rst_mult_b", bus.mult_b, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    bus.req_valid = '0;
    step();
    rst = 1'b0;
    step();

    // Round robin with every requester valid and the consumer always ready.
    gnt_exp = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 2), 8'(i + 11));
    for (int i = 0; i < 6; i++) expect_rsp(gnt_exp[i][1:0], 8'((gnt_exp[i] + 2) * (gnt_exp[i] + 11)));
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    acc = 0; rsp = 0; last_acc = -1; cyc = 0;
    while (rsp < 6 && cyc < 60) begin
      #1;
      check("rr_onehot", $countones(bus.req_ready) <= 1, 1);
      if (bus.req_ready != '0) begin
        g = 0;
        for (int j = 0; j < NREQ; j++) if (bus.req_ready[j]) g = j;
        if (acc < 6) check("rr_order", g, gnt_exp[acc]);
        if (acc > 0) check("rr_spacing", cyc - last_acc, 3);
        last_acc = cyc;
        acc++;
      end
      if (bus.rsp_valid && bus.rsp_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("rr_rsp_id", bus.rsp_id, e.id);
        check("rr_rsp_data", bus.rsp_data, e.data);
        rsp++;
      end
      if (acc == 6 && bus.busy) bus.req_valid = '0;
      step();
      cyc++;
    end
    check("rr_done", rsp, 6);
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    step();

    // Single request from requester 2 with full latency checks.
    set_op(2, 8'd3, 8'd5);
    bus.req_valid = 4'b0100;
    expect_rsp(2'd2, 8'd15);
    #1;
    check("t1_ready", bus.req_ready, 4'b0100);
    check("t1_busy_idle", bus.busy, 0);
    step();
    bus.req_valid = '0;
    check("t1_busy_calc", bus.busy, 1);
    check("t1_no_rsp_calc", bus.rsp_valid, 0);
    check("t1_mult_a", bus.mult_a, 8'd3);
    check("t1_mult_b", bus.mult_b, 8'd5);
    step();
    check("t1_rsp_valid", bus.rsp_valid, 1);
    check("t1_busy_resp", bus.busy, 1);
    wait_rsp(4);
    check("t1_busy_done", bus.busy, 0);
    check("t1_rsp_low", bus.rsp_valid, 0);

    // Backpressure: response held for five cycles while others wait.
    set_op(1, 8'd7, 8'd9);
    bus.req_valid = 4'b0010;
    expect_rsp(2'd1, 8'd63);
    #1;
    check("t3_ready", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = 4'b1101;
    step();
    for (int i = 0; i < 5; i++) begin
      check("t3_valid_hold", bus.rsp_valid, 1);
      check("t3_data_hold", bus.rsp_data, 8'd63);
      check("t3_id_hold", bus.rsp_id, 1);
      check("t3_no_ready", bus.req_ready, 0);
      step();
    end
    bus.req_valid = '0;
    wait_rsp(2);

    // Truncation and edge operands.
    do_txn(0, 8'd20, 8'd13, 8'h04);
    do_txn(2, 8'hFF, 8'hFF, 8'h01);
    do_txn(1, 8'h00, 8'hAA, 8'h00);

    // Reset during CALC drops the transaction and restores the pointer.
    set_op(2, 8'd6, 8'd7);
    bus.req_valid = 4'b0100;
    #1;
    check("t5_ready", bus.req_ready, 4'b0100);
    step();
    bus.req_valid = '0;
    check("t5_in_calc", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_valid", bus.rsp_valid, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_no_rsp", bus.rsp_valid, 0);
      step();
    end
    set_op(1, 8'd4, 8'd5);
    set_op(3, 8'd9, 8'd9);
    bus.req_valid = 4'b1010;
    expect_rsp(2'd1, 8'd20);
    #1;
    check("t5_first_gnt", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = '0;
    wait_rsp(6);

    // Retraction: requester 0 pulses valid only while the block is in RESP.
    set_op(3, 8'd3, 8'd4);
    bus.req_valid = 4'b1000;
    expect_rsp(2'd3, 8'd12);
    #1;
    check("t6_ready_a", bus.req_ready, 4'b1000);
    step();
    bus.req_valid = '0;
    step();
    check("t6_in_resp", bus.rsp_valid, 1);
    bus.req_valid = 4'b0001;
    #1;
    check("t6_no_ready_resp", bus.req_ready, 0);
    step();
    bus.req_valid = 4'b1000;
    set_op(3, 8'd11, 8'd5);
    check("t6_mult_a_stable", bus.mult_a, 8'd3);
    check("t6_mult_b_stable", bus.mult_b, 8'd4);
    wait_rsp(2);
    expect_rsp(2'd3, 8'd55);
    #1;
    check("t6_only3", bus.req_ready, 4'b1000);
    step();
    bus.req_valid = '0;
    wait_rsp(6);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational 8-bit Wallace tree multiplier among NREQ requesters.
- Accepts one operand pair per transaction through a valid/ready handshake and drives the registered operands to the multiplier.
- Waits one settle cycle, then captures the multiplier output and returns it with the requester ID through a valid/ready response port.
- The multiplier sits outside this block and is connected through the mult_a, mult_b and mult_out ports.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, operand width; must equal the multiplier input width
- PW, 8, product width returned by the multiplier (its Out width)
- IDW, $clog2(NREQ), requester ID width (derived; not overridable)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  NREQ*DW  packed operand A; requester i uses bits [i*DW +: DW]
- req_b  in  NREQ*DW  packed operand B, same packing
- mult_a  out  DW  operand A to the multiplier (registered)
- mult_b  out  DW  operand B to the multiplier (registered)
- mult_out  in  PW  multiplier result (combinational from mult_a/mult_b)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of the requester that owns the response
- rsp_data  out  PW  captured product
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=NREQ-1, so requester 0 has first priority.
  - op_a, op_b, rsp_data and rsp_id reset to 0.
  - rsp_valid=0, busy=0, req_ready=0.
- The FSM has three states: IDLE, CALC and RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - req_ready is combinational, one-hot on the winner, and driven only in IDLE; it is 0 when no request is valid.
  - On a handshake (req_valid[g] & req_ready[g]): latch op_a<=req_a[g], op_b<=req_b[g], rsp_id<=g, then go to CALC.
  - With no valid request, stay in IDLE.
- CALC:
  - One cycle for the multiplier to settle.
  - At the clock edge ending CALC: rsp_data<=mult_out, rsp_valid<=1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable.
  - On rsp_ready=1: rsp_valid<=0, rr_ptr<=rsp_id, go to IDLE.
  - No new request is accepted in the cycle of the response handshake.
- mult_a and mult_b always equal op_a and op_b. They are stable from the CALC cycle through RESP and do not change until the next accept.
- Latency and throughput:
  - Accept edge at T; rsp_valid is high in the cycle after edge T+1.
  - Minimum spacing between accepts is 3 cycles when rsp_ready is held at 1.
- Width rule: rsp_data = mult_out unmodified. The product is truncated to PW bits by the multiplier, and this block does no extension.
- Requesters may deassert req_valid before they are granted; arbitration is re-evaluated every IDLE cycle. After a handshake, the requester must not expect a second accept for the same data.
- The pointer advances only on a completed response, which gives fairness:
  - A requester that stays valid is granted within NREQ transactions.
  - Each requester gets exactly one grant per round when all requesters are continuously valid.
- Zero operands are legal; 0 in either operand gives rsp_data=0.
- Reset mid-operation (CALC or RESP): the transaction is dropped, no response is issued, and rr_ptr returns to NREQ-1.
- rsp_ready high while rsp_valid=0 is ignored.

Test Plan:
- Single request: req 2 valid with a=3, b=5 -> req_ready[2] high in the same cycle; rsp_valid 2 cycles after accept; rsp_id=2, rsp_data=15; busy high from CALC to RESP.
- Round-robin: all 4 requesters continuously valid, rsp_ready=1 -> grant order 0,1,2,3,0,1; accepts 3 cycles apart; req_ready never multi-hot.
- Backpressure: a=7, b=9, rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data=63 and rsp_id stay stable; req_ready stays 0 throughout; completes when rsp_ready=1.
- Truncation and edge values: a=20, b=13 -> rsp_data=0x04 (260 mod 256); a=0xFF, b=0xFF -> 0x01; a=0, b=0xAA -> 0x00.
- Reset mid-op: assert rst during CALC -> rsp_valid never rises; after release with reqs 1 and 3 valid, requester 1 is granted first.
- Retraction: req 0 valid for 1 cycle while the block is in RESP, then dropped; req 3 valid -> on return to IDLE only req 3 is granted; rsp_id=3.
